// File: rtl/halloween_actuator.sv
// ---------------------------------------------------------------------------
// halloween_actuator
//
// Consumer end of the decoration opcode stream. Accepts 4-bit opcodes
// {class[1:0], operand[1:0]} over a valid/ready handshake. Decodes them into
// power state, light colour, timed sound playback and timed hand/jaw/fog
// effects. Every actuator output is a flop, so an accepted opcode becomes
// visible in the cycle after the accepting edge.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous, active-high reset
//   opcode       - {class, operand}
//   op_valid     - opcode present
//   op_ready     - opcode will be accepted this cycle (combinational)
//   power_on     - decoration powered
//   color        - 00 dark, 01 green, 10 purple, 11 orange
//   sound_active - sound playing
//   sound_sel    - 00 scream, 01 cackle, 10 boo (00 when idle)
//   wave_hands   - hand-wave actuator
//   move_jaw     - jaw actuator
//   fog          - fog machine
//   illegal_op   - one-cycle pulse on an accepted undefined opcode
//   fog_dropped  - one-cycle pulse on a fog trigger dropped by cooldown
// ---------------------------------------------------------------------------
module halloween_actuator #(
  parameter int unsigned SOUND_CYCLES  = 8,
  parameter int unsigned EFFECT_CYCLES = 6,
  parameter int unsigned FOG_CYCLES    = 10,
  parameter int unsigned FOG_COOLDOWN  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       op_valid,
  output logic       op_ready,
  output logic       power_on,
  output logic [1:0] color,
  output logic       sound_active,
  output logic [1:0] sound_sel,
  output logic       wave_hands,
  output logic       move_jaw,
  output logic       fog,
  output logic       illegal_op,
  output logic       fog_dropped
);

  // Power FSM states
  localparam logic [0:0] StOff = 1'b0;
  localparam logic [0:0] StOn  = 1'b1;

  // Opcode classes and the two power-class opcodes
  localparam logic [1:0] ClsPower  = 2'b00;
  localparam logic [1:0] ClsColor  = 2'b01;
  localparam logic [1:0] ClsSound  = 2'b10;
  localparam logic [1:0] ClsEffect = 2'b11;
  localparam logic [3:0] OpOn      = 4'b0000;
  localparam logic [3:0] OpReset   = 4'b0001;

  // Effect-class operands
  localparam logic [1:0] EffWave = 2'b00;
  localparam logic [1:0] EffJaw  = 2'b01;
  localparam logic [1:0] EffFog  = 2'b10;

  localparam logic [7:0] SoundLoad  = 8'(SOUND_CYCLES);
  localparam logic [7:0] EffectLoad = 8'(EFFECT_CYCLES);
  localparam logic [7:0] FogLoad    = 8'(FOG_CYCLES);
  localparam logic [7:0] CoolLoad   = 8'(FOG_COOLDOWN);

  logic [0:0] state_q, state_d;
  logic [1:0] color_q, color_d;
  logic [1:0] soundSel_q, soundSel_d;
  logic [7:0] soundCnt_q, soundCnt_d;
  logic [7:0] waveCnt_q, waveCnt_d;
  logic [7:0] jawCnt_q, jawCnt_d;
  logic [7:0] fogCnt_q, fogCnt_d;
  logic [7:0] coolCnt_q, coolCnt_d;
  logic       soundActive_q, soundActive_d;
  logic       waveHands_q, waveHands_d;
  logic       moveJaw_q, moveJaw_d;
  logic       fog_q, fog_d;
  logic       illegal_q, illegal_d;
  logic       fogDropped_q, fogDropped_d;

  logic [1:0] opClass;
  logic [1:0] operand;
  logic       opDefined;
  logic       accept;

  assign opClass = opcode[3:2];
  assign operand = opcode[1:0];

  // Operand 11 is undefined in every class; the power class also has no
  // operand 10.
  assign opDefined = (operand != 2'b11) && !((opClass == ClsPower) && operand[1]);

  // A new sound must wait until the current one has finished playing; every
  // other opcode is always taken.
  always_comb begin
    op_ready = !(soundActive_q && (opClass == ClsSound));
  end

  assign accept = op_valid && op_ready;

  // Next-state logic: counters free-run down to zero, then the accepted
  // opcode (if any) overrides. Output flags are derived from the next count
  // so they change on the same edge as the counter load.
  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    soundSel_d   = soundSel_q;
    soundCnt_d   = (soundCnt_q != 8'd0) ? soundCnt_q - 8'd1 : soundCnt_q;
    waveCnt_d    = (waveCnt_q  != 8'd0) ? waveCnt_q  - 8'd1 : waveCnt_q;
    jawCnt_d     = (jawCnt_q   != 8'd0) ? jawCnt_q   - 8'd1 : jawCnt_q;
    fogCnt_d     = (fogCnt_q   != 8'd0) ? fogCnt_q   - 8'd1 : fogCnt_q;
    illegal_d    = 1'b0;
    fogDropped_d = 1'b0;

    // The cooldown starts on the edge where fog falls.
    if (fogCnt_q == 8'd1) begin
      coolCnt_d = CoolLoad;
    end else if (coolCnt_q != 8'd0) begin
      coolCnt_d = coolCnt_q - 8'd1;
    end else begin
      coolCnt_d = coolCnt_q;
    end

    if (accept) begin
      if (!opDefined) begin
        illegal_d = 1'b1;
      end else if (opcode == OpReset) begin
        state_d    = StOff;
        color_d    = 2'b00;
        soundSel_d = 2'b00;
        soundCnt_d = 8'd0;
        waveCnt_d  = 8'd0;
        jawCnt_d   = 8'd0;
        fogCnt_d   = 8'd0;
        coolCnt_d  = 8'd0;
      end else if (opcode == OpOn) begin
        if (state_q == StOff) begin
          color_d = 2'b00;
        end
        state_d = StOn;
      end else if (state_q == StOn) begin
        case (opClass)
          ClsColor: color_d = operand + 2'd1;
          ClsSound: begin
            soundSel_d = operand;
            soundCnt_d = SoundLoad;
          end
          ClsEffect: begin
            case (operand)
              EffWave: waveCnt_d = EffectLoad;
              EffJaw:  jawCnt_d  = EffectLoad;
              EffFog: begin
                // A retrigger while fog is running extends it and must not
                // start a cooldown on this edge.
                if (fogCnt_q != 8'd0) begin
                  fogCnt_d  = FogLoad;
                  coolCnt_d = 8'd0;
                end else if (coolCnt_q != 8'd0) begin
                  fogDropped_d = 1'b1;
                end else begin
                  fogCnt_d = FogLoad;
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end

    soundActive_d = (soundCnt_d != 8'd0);
    waveHands_d   = (waveCnt_d  != 8'd0);
    moveJaw_d     = (jawCnt_d   != 8'd0);
    fog_d         = (fogCnt_d   != 8'd0);
    if (soundCnt_d == 8'd0) begin
      soundSel_d = 2'b00;
    end
  end

  // State and output registers; hardware reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StOff;
      color_q       <= 2'b00;
      soundSel_q    <= 2'b00;
      soundCnt_q    <= 8'd0;
      waveCnt_q     <= 8'd0;
      jawCnt_q      <= 8'd0;
      fogCnt_q      <= 8'd0;
      coolCnt_q     <= 8'd0;
      soundActive_q <= 1'b0;
      waveHands_q   <= 1'b0;
      moveJaw_q     <= 1'b0;
      fog_q         <= 1'b0;
      illegal_q     <= 1'b0;
      fogDropped_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      color_q       <= color_d;
      soundSel_q    <= soundSel_d;
      soundCnt_q    <= soundCnt_d;
      waveCnt_q     <= waveCnt_d;
      jawCnt_q      <= jawCnt_d;
      fogCnt_q      <= fogCnt_d;
      coolCnt_q     <= coolCnt_d;
      soundActive_q <= soundActive_d;
      waveHands_q   <= waveHands_d;
      moveJaw_q     <= moveJaw_d;
      fog_q         <= fog_d;
      illegal_q     <= illegal_d;
      fogDropped_q  <= fogDropped_d;
    end
  end

  assign power_on     = (state_q == StOn);
  assign color        = color_q;
  assign sound_active = soundActive_q;
  assign sound_sel    = soundSel_q;
  assign wave_hands   = waveHands_q;
  assign move_jaw     = moveJaw_q;
  assign fog          = fog_q;
  assign illegal_op   = illegal_q;
  assign fog_dropped  = fogDropped_q;

endmodule

// File: tb/tb_halloween_actuator.sv
// ---------------------------------------------------------------------------
// tb_halloween_actuator
//
// Bench for halloween_actuator. The reference model tracks, for every timed
// output, the edge number at which it must end; an output is expected high
// while the current edge count is below that end time. The fog cooldown is
// the window of FOG_COOLDOWN cycles starting at the fog end time.
// ---------------------------------------------------------------------------
module tb_halloween_actuator;

  localparam int SoundCycles  = 8;
  localparam int EffectCycles = 6;
  localparam int FogCycles    = 10;
  localparam int FogCooldown  = 12;
  localparam int Never        = -100000;

  localparam logic [3:0] OpOn     = 4'b0000;
  localparam logic [3:0] OpReset  = 4'b0001;
  localparam logic [3:0] OpGreen  = 4'b0100;
  localparam logic [3:0] OpPurple = 4'b0101;
  localparam logic [3:0] OpOrange = 4'b0110;
  localparam logic [3:0] OpScream = 4'b1000;
  localparam logic [3:0] OpCackle = 4'b1001;
  localparam logic [3:0] OpBoo    = 4'b1010;
  localparam logic [3:0] OpWave   = 4'b1100;
  localparam logic [3:0] OpJaw    = 4'b1101;
  localparam logic [3:0] OpFog    = 4'b1110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic       power_on;
  logic [1:0] color;
  logic       sound_active;
  logic [1:0] sound_sel;
  logic       wave_hands;
  logic       move_jaw;
  logic       fog;
  logic       illegal_op;
  logic       fog_dropped;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  // Reference model state
  bit         mPower;
  logic [1:0] mColor;
  logic [1:0] mSel;
  int         soundEnd;
  int         waveEnd;
  int         jawEnd;
  int         fogEnd;
  bit         expIllegal;
  bit         expDrop;

  always #5 clk = ~clk;

  halloween_actuator #(
    .SOUND_CYCLES (SoundCycles),
    .EFFECT_CYCLES(EffectCycles),
    .FOG_CYCLES   (FogCycles),
    .FOG_COOLDOWN (FogCooldown)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .power_on    (power_on),
    .color       (color),
    .sound_active(sound_active),
    .sound_sel   (sound_sel),
    .wave_hands  (wave_hands),
    .move_jaw    (move_jaw),
    .fog         (fog),
    .illegal_op  (illegal_op),
    .fog_dropped (fog_dropped)
  );

  // Single comparison point; every check goes through here.
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cur);
    end
  endtask

  task automatic modelClear();
    mPower   = 1'b0;
    mColor   = 2'b00;
    mSel     = 2'b00;
    soundEnd = Never;
    waveEnd  = Never;
    jawEnd   = Never;
    fogEnd   = Never;
  endtask

  function automatic bit isDefined(input logic [3:0] op);
    return op inside {OpOn, OpReset, OpGreen, OpPurple, OpOrange, OpScream,
                      OpCackle, OpBoo, OpWave, OpJaw, OpFog};
  endfunction

  // Compare every registered output against the model.
  task automatic checkOutput();
    bit sAct;
    sAct = (cur < soundEnd);
    cmp("power_on", power_on, mPower);
    cmp("color", color, mColor);
    cmp("sound_active", sound_active, sAct);
    cmp("sound_sel", sound_sel, sAct ? mSel : 2'b00);
    cmp("wave_hands", wave_hands, cur < waveEnd);
    cmp("move_jaw", move_jaw, cur < jawEnd);
    cmp("fog", fog, cur < fogEnd);
    cmp("illegal_op", illegal_op, expIllegal);
    cmp("fog_dropped", fog_dropped, expDrop);
  endtask

  // Drive one cycle's inputs just after a falling edge, check op_ready,
  // advance the model for the coming rising edge, then check outputs.
  task automatic applyStimulus(input bit v, input logic [3:0] op);
    bit ready;
    bit acc;
    int en;
    opcode   = op;
    op_valid = v;
    #1;
    ready = !((cur < soundEnd) && (op[3:2] == 2'b10));
    cmp("op_ready", op_ready, ready);
    acc = v && ready;
    en  = cur + 1;
    expIllegal = 1'b0;
    expDrop    = 1'b0;
    if (acc) begin
      if (!isDefined(op)) begin
        expIllegal = 1'b1;
      end else if (op == OpReset) begin
        modelClear();
      end else if (op == OpOn) begin
        mPower = 1'b1;
      end else if (mPower) begin
        case (op)
          OpGreen, OpPurple, OpOrange: mColor = op[1:0] + 2'd1;
          OpScream, OpCackle, OpBoo: begin
            mSel     = op[1:0];
            soundEnd = en + SoundCycles;
          end
          OpWave: waveEnd = en + EffectCycles;
          OpJaw:  jawEnd  = en + EffectCycles;
          OpFog: begin
            if (cur < fogEnd) fogEnd = en + FogCycles;
            else if (cur < fogEnd + FogCooldown) expDrop = 1'b1;
            else fogEnd = en + FogCycles;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    cur++;
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, OpScream);
  endtask

  // Assert rst away from a rising edge; outputs must drop at once.
  task automatic doReset();
    rst = 1'b1;
    #2;
    modelClear();
    expIllegal = 1'b0;
    expDrop    = 1'b0;
    cmp("reset fog", fog, 0);
    cmp("reset op_ready", op_ready, 1);
    checkOutput();
    @(posedge clk);
    cur++;
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int count;
    int stalls;
    bit ready;
    logic [3:0] op;
    int r;

    opcode   = OpOn;
    op_valid = 1'b0;
    modelClear();
    doReset();

    // Power-up and colour: GREEN before ON is ignored.
    applyStimulus(1'b1, OpGreen);
    cmp("green while off", color, 2'b00);
    applyStimulus(1'b1, OpOn);
    cmp("power after ON", power_on, 1);
    applyStimulus(1'b1, OpOrange);
    cmp("orange colour", color, 2'b11);

    // Scream, then BOO held valid until the gap cycle.
    applyStimulus(1'b1, OpScream);
    cmp("scream sel", sound_sel, 2'b00);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      ready = !(cur < soundEnd);
      applyStimulus(1'b1, OpBoo);
      if (ready) break;
      stalls++;
    end
    cmp("boo stall cycles", stalls, 8);
    cmp("boo sel", sound_sel, 2'b10);
    idle(9);
    cmp("boo finished sel", sound_sel, 2'b00);

    // Hand-wave retrigger four cycles after the first trigger.
    count = 0;
    applyStimulus(1'b1, OpWave);
    count += wave_hands;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      count += wave_hands;
    end
    applyStimulus(1'b1, OpWave);
    count += wave_hands;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      count += wave_hands;
    end
    cmp("wave high cycles", count, 10);

    // Fog, a trigger during cooldown, then a trigger after cooldown.
    count = 0;
    applyStimulus(1'b1, OpFog);
    count += fog;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      count += fog;
    end
    cmp("first fog cycles", count, 10);
    applyStimulus(1'b1, OpFog);
    cmp("fog dropped pulse", fog_dropped, 1);
    cmp("fog stays low", fog, 0);
    idle(1);
    cmp("fog dropped one cycle", fog_dropped, 0);
    idle(11);
    count = 0;
    applyStimulus(1'b1, OpFog);
    count += fog;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      count += fog;
    end
    cmp("second fog cycles", count, 10);

    // RESET opcode mid-sound and mid-effect.
    applyStimulus(1'b1, OpCackle);
    applyStimulus(1'b1, OpJaw);
    idle(1);
    applyStimulus(1'b1, OpReset);
    cmp("reset opcode power", power_on, 0);
    cmp("reset opcode sound", sound_active, 0);
    cmp("reset opcode jaw", move_jaw, 0);
    applyStimulus(1'b1, OpPurple);
    cmp("purple after reset", color, 2'b00);

    // Undefined opcodes in OFF and ON.
    applyStimulus(1'b1, 4'b0011);
    cmp("illegal 0011 off", illegal_op, 1);
    applyStimulus(1'b1, OpOn);
    applyStimulus(1'b1, 4'b0011);
    cmp("illegal 0011 on", illegal_op, 1);
    applyStimulus(1'b1, 4'b1111);
    cmp("illegal 1111 on", illegal_op, 1);
    idle(1);

    // Asynchronous reset while fog is running.
    applyStimulus(1'b1, OpFog);
    idle(3);
    cmp("fog before async reset", fog, 1);
    doReset();

    // Randomized traffic with a bias towards power-on.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) op = OpReset;
      else if (r < 12) op = OpOn;
      else op = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 3) != 0, op);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/halloween_actuator.md
Name: halloween_actuator

Overview:
Consumer end of the decoration opcode stream. Accepts 4-bit opcodes (2-bit class, 2-bit operand) from the sequencer's channel mux over a valid/ready handshake. Decodes them and drives the decoration's power, light colour, timed sound playback and timed movement/fog effects. Sits between the opcode sequencer and the physical actuator outputs.

Parameters:
SOUND_CYCLES, 8, cycles sound_active stays high per accepted sound (1..255)
EFFECT_CYCLES, 6, cycles wave_hands / move_jaw stay high per trigger (1..255)
FOG_CYCLES, 10, cycles fog stays high per trigger (1..255)
FOG_COOLDOWN, 12, cycles after fog ends during which fog triggers are dropped (0..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  4  {class[1:0], operand[1:0]}
op_valid  input  1  opcode present
op_ready  output  1  block will accept opcode this cycle
power_on  output  1  decoration powered
color  output  2  00 dark, 01 green, 10 purple, 11 orange
sound_active  output  1  sound playing
sound_sel  output  2  00 scream, 01 cackle, 10 boo (held while active, 00 when idle)
wave_hands  output  1  hand-wave actuator
move_jaw  output  1  jaw actuator
fog  output  1  fog machine
illegal_op  output  1  one-cycle pulse on accepted undefined opcode
fog_dropped  output  1  one-cycle pulse on fog trigger dropped by cooldown

Behaviour:
- Reset (async, rst=1): every output 0 except op_ready=1; all counters 0; power state OFF.
- Opcodes: 0000 ON, 0001 RESET, 0100 GREEN, 0101 PURPLE, 0110 ORANGE, 1000 SCREAMING, 1001 CACKLING, 1010 BOO, 1100 WAVEHANDS, 1101 MOVEJAW, 1110 FOG. All others undefined.
- Accept = op_valid & op_ready at rising clk. Every output is registered: effects are visible the cycle after the accepting edge.
- op_ready = 0 only when sound_active=1 and opcode[3:2]=10 (sound stalls behind a playing sound). Otherwise op_ready=1, combinational from opcode and state.
- Power FSM: OFF, ON.
  - OFF: ON -> state ON, color=00. Every other opcode is accepted and ignored. Undefined opcodes still pulse illegal_op.
  - ON: ON is a no-op.
  - RESET in either state -> OFF. Clears all outputs and counters, including fog cooldown, identical to hardware reset except it is synchronous.
- Colour (ON only): load color = operand+1. Held until the next colour opcode, RESET or rst.
- Sound (ON only):
  - Load sound_sel = operand, counter = SOUND_CYCLES.
  - sound_active is high for exactly SOUND_CYCLES cycles, then sound_sel returns to 00.
  - A sound waiting on a stall is accepted in the first cycle sound_active=0, so back-to-back sounds have a one-cycle gap.
- WAVEHANDS / MOVEJAW (ON only): independent counters. Output high for EFFECT_CYCLES cycles. A retrigger while active reloads the counter, so the output stays high EFFECT_CYCLES cycles after the last trigger with no glitch.
- FOG (ON only):
  - Idle, no cooldown: fog high for FOG_CYCLES cycles.
  - While fog is high: retrigger reloads the counter.
  - On fog falling: cooldown counter = FOG_COOLDOWN.
  - While cooldown is nonzero: fog triggers are accepted, ignored, and pulse fog_dropped.
- Undefined opcode: accepted, no state change, illegal_op pulses one cycle (both states).
- op_valid=0: no acceptance. Counters keep running.
- Counters are 8-bit and decrement to 0 and stop. No wrap-around.
- rst asserted mid-sound or mid-effect: outputs drop asynchronously. Nothing resumes after release.

Test Plan:
- rst pulse, then ON, then ORANGE back-to-back -> power_on=1 after edge 1, color=11 after edge 2; before ON, a GREEN is ignored (color stays 00).
- ON, SCREAMING, then BOO held valid -> sound_active high 8 cycles with sound_sel=00; op_ready=0 during those 8; BOO accepted in gap cycle; sound_sel=10 for the next 8 cycles.
- ON, WAVEHANDS at t, WAVEHANDS again at t+4 -> wave_hands continuous high 10 cycles total, then 0.
- ON, FOG, FOG again 3 cycles after fog falls -> first fog high 10 cycles; second accepted with fog_dropped=1 for one cycle, fog stays 0; FOG after 12 cooldown cycles -> fog high 10 cycles.
- ON, CACKLING, MOVEJAW, then RESET opcode 2 cycles later -> all outputs 0 next edge, power_on=0; subsequent PURPLE ignored.
- Opcodes 0011 and 1111 in ON and OFF states -> illegal_op one-cycle pulse each, no other output change; async rst mid-fog -> fog=0 immediately.
